// File: rtl/mem_iface.sv
// mem_iface: LC-3 MAR/MDR and memory-cycle handshake returning the ready bit.
// Define MMIO_EN to decode KBSR/KBDR/DSR/DDR (0xFE00-0xFE06) locally.
module mem_iface (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bus_in,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        r_w,
  output logic [15:0] mdr_out,
  output logic        mem_r,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_req,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        kb_strobe,
  input  logic [7:0]  kb_char,
  input  logic        disp_ready,
  output logic [7:0]  disp_char,
  output logic        disp_strobe
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE, HOLD} state_t;
  state_t state, state_nx;
  logic [15:0] mar, mdr, local_rdata;
  logic we, local_hit, start;
  assign start = state == IDLE && mio_en;
`ifdef MMIO_EN
  logic kb_full, ddr_wr;
  logic [7:0] kb_buf;
  assign local_hit = mar[15:3] == 13'h1fc0 && !mar[0];
  always_comb
    local_rdata = mar[2:1] == 2'd0 ? {kb_full, 15'b0} :
                  mar[2:1] == 2'd1 ? {8'h00, kb_buf} :
                  mar[2:1] == 2'd2 ? {disp_ready, 15'b0} : 16'h0000;
  // a keyboard strobe beats the KBDR read-clear on the same edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      kb_full <= 1'b0;
      kb_buf <= 8'h00;
      ddr_wr <= 1'b0;
      disp_char <= 8'h00;
    end else begin
      if (kb_strobe) begin
        kb_full <= 1'b1;
        kb_buf <= kb_char;
      end else if (start && local_hit && !r_w && mar[2:1] == 2'd1)
        kb_full <= 1'b0;
      if (start)
        ddr_wr <= local_hit && r_w && mar[2:1] == 2'd3;
      if (start && local_hit && r_w && mar[2:1] == 2'd3)
        disp_char <= mdr[7:0];
    end
  assign disp_strobe = state == DONE && ddr_wr;
`else
  logic unused_mmio;
  assign unused_mmio = ^{kb_strobe, kb_char, disp_ready};
  assign local_hit = 1'b0;
  assign local_rdata = 16'h0000;
  assign disp_char = 8'h00;
  assign disp_strobe = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      mar <= 16'h0000;
      mdr <= 16'h0000;
      we <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        if (ld_mar) mar <= bus_in;
        if (ld_mdr) mdr <= bus_in;
        if (mio_en) we <= r_w;
        if (start && local_hit && !r_w) mdr <= local_rdata;
      end
      if (state == BUSY && mem_ack && !we) mdr <= mem_rdata;
    end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (mio_en) state_nx = local_hit ? DONE : BUSY;
      BUSY: if (mem_ack) state_nx = DONE;
      DONE: state_nx = HOLD;
      HOLD: if (!mio_en) state_nx = IDLE;
    endcase
  end
  assign mem_req = state == BUSY;
  assign mem_we = mem_req && we;
  assign mem_r = state == DONE;
  assign mdr_out = mdr;
  assign mem_addr = mar;
  assign mem_wdata = mdr;
endmodule

// File: tb/tb_mem_iface.sv
// tb_mem_iface: transaction-level model of mem_iface checked against the DUT every cycle.
module tb_mem_iface;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] bus_in = '0, mem_rdata = '0;
  logic ld_mar = 0, ld_mdr = 0, mio_en = 0, r_w = 0, mem_ack = 0;
  logic kb_strobe = 0, disp_ready = 0;
  logic [7:0] kb_char = '0;
  logic [15:0] mdr_out, mem_addr, mem_wdata;
  logic mem_r, mem_req, mem_we, disp_strobe;
  logic [7:0] disp_char;

  mem_iface dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .mdr_out(mdr_out), .mem_r(mem_r),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .kb_strobe(kb_strobe), .kb_char(kb_char),
    .disp_ready(disp_ready), .disp_char(disp_char), .disp_strobe(disp_strobe)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int req_cyc = 0, req_starts = 0, r_cnt = 0, ds_cnt = 0;
  logic prev_req = 0, chk_on = 0;
  logic [15:0] exp_mar = 0, exp_mdr = 0;
  logic exp_req = 0, exp_we = 0, exp_r = 0, exp_ds = 0;
  logic [7:0] exp_dc = 0;
  logic kfull = 0;
  logic [7:0] kbuf = 0;

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("mdr_out", mdr_out, exp_mdr);
      chk("mem_wdata", mem_wdata, exp_mdr);
      chk("mem_addr", mem_addr, exp_mar);
      chk("mem_req", {15'b0, mem_req}, {15'b0, exp_req});
      chk("mem_we", {15'b0, mem_we}, {15'b0, exp_we});
      chk("mem_r", {15'b0, mem_r}, {15'b0, exp_r});
      chk("disp_char", {8'b0, disp_char}, {8'b0, exp_dc});
      chk("disp_strobe", {15'b0, disp_strobe}, {15'b0, exp_ds});
    end
    if (mem_req) req_cyc++;
    if (mem_req && !prev_req) req_starts++;
    if (mem_r) r_cnt++;
    if (disp_strobe) ds_cnt++;
    prev_req = mem_req;
  end

  function automatic logic is_local(input logic [15:0] a);
`ifdef MMIO_EN
    return a == 16'hFE00 || a == 16'hFE02 || a == 16'hFE04 || a == 16'hFE06;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] local_read(input logic [15:0] a);
    if (a == 16'hFE00) return {kfull, 15'b0};
    if (a == 16'hFE02) return {8'h00, kbuf};
    if (a == 16'hFE04) return {disp_ready, 15'b0};
    return 16'h0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    exp_r = 0;
    exp_ds = 0;
  endtask

  task automatic kb_press(input logic [7:0] c);
    kb_strobe = 1;
    kb_char = c;
    step();
    kb_strobe = 0;
    kfull = 1;
    kbuf = c;
  endtask

  // one full memory cycle: load MAR (and MDR on writes), run it, then leave HOLD
  task automatic txn(input logic [15:0] addr, input logic [15:0] data, input logic wr,
                     input int lat, input int hold_n, input logic drop,
                     input logic kb, input logic [7:0] kc);
    logic [15:0] rd;
    logic loc;
    int hn;
    loc = is_local(addr);
    hn = drop ? 0 : hold_n;
    bus_in = addr; ld_mar = 1;
    step();
    exp_mar = addr; ld_mar = 0;
    if (wr) begin
      bus_in = data; ld_mdr = 1;
      step();
      exp_mdr = data; ld_mdr = 0;
    end
    mio_en = 1; r_w = wr; disp_ready = 1'($urandom);
    if (kb) begin kb_strobe = 1; kb_char = kc; end
    rd = local_read(addr);
    step();
    kb_strobe = 0;
    if (kb) begin kfull = 1; kbuf = kc; end
    else if (loc && !wr && addr == 16'hFE02) kfull = 0;
    if (loc) begin
      exp_r = 1;
      if (!wr) exp_mdr = rd;
      if (wr && addr == 16'hFE06) begin exp_dc = exp_mdr[7:0]; exp_ds = 1; end
    end else begin
      rd = data;
      for (int k = 1; k <= lat; k++) begin
        exp_req = 1; exp_we = wr;
        mem_ack = (k == lat);
        mem_rdata = (k == lat) ? data : 16'($urandom);
        bus_in = 16'h5555; ld_mar = 1; ld_mdr = 1;
        if (drop) mio_en = 0;
        step();
      end
      mem_ack = 0; ld_mar = 0; ld_mdr = 0;
      exp_req = 0; exp_we = 0; exp_r = 1;
      if (!wr) exp_mdr = rd;
    end
    mio_en = (hn > 0);
    step();
    for (int h = 0; h < hn; h++) begin
      bus_in = 16'($urandom); ld_mar = 1'($urandom); ld_mdr = 1'($urandom);
      step();
    end
    mio_en = 0; ld_mar = 0; ld_mdr = 0;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, c1, c2, c3;
    logic [15:0] a;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mdr", mdr_out, 16'h0);
    chk("rst_addr", mem_addr, 16'h0);
    chk("rst_req", {15'b0, mem_req}, 16'h0);
    chk("rst_r", {15'b0, mem_r}, 16'h0);
    chk("rst_disp", {7'b0, disp_strobe, disp_char}, 16'h0);
    rst = 0;
    chk_on = 1;
    step();

    c0 = req_cyc; c1 = r_cnt;
    txn(16'h3000, 16'hBEEF, 0, 3, 0, 0, 0, 8'h00);
    chk("beef_mdr", mdr_out, 16'hBEEF);
    chk("beef_req_cycles", 16'(req_cyc - c0), 16'd3);
    chk("beef_r_pulses", 16'(r_cnt - c1), 16'd1);

    txn(16'h4000, 16'h1234, 1, 1, 2, 0, 0, 8'h00);
    chk("wr_addr", mem_addr, 16'h4000);
    chk("wr_data", mem_wdata, 16'h1234);

    c0 = req_starts; c1 = r_cnt;
    txn(16'h3001, 16'h0F0F, 0, 2, 10, 0, 0, 8'h00);
    chk("held_req_starts", 16'(req_starts - c0), 16'd1);
    chk("held_r_pulses", 16'(r_cnt - c1), 16'd1);

    // reset in the middle of a request
    bus_in = 16'h3000; ld_mar = 1;
    step();
    exp_mar = 16'h3000; ld_mar = 0; mio_en = 1; r_w = 0;
    step();
    exp_req = 1;
    step();
    rst = 1;
    #1;
    chk("async_rst_req", {15'b0, mem_req}, 16'h0);
    chk("async_rst_addr", mem_addr, 16'h0);
    exp_req = 0; exp_we = 0; exp_mar = 0; exp_mdr = 0; exp_dc = 0; kfull = 0; kbuf = 0;
    mio_en = 0;
    c1 = r_cnt;
    step();
    rst = 0;
    step();
    chk("rst_no_r", 16'(r_cnt - c1), 16'd0);
    txn(16'h3002, 16'hA5A5, 0, 1, 0, 1, 0, 8'h00);
    chk("post_rst_mdr", mdr_out, 16'hA5A5);

`ifdef MMIO_EN
    c0 = req_cyc; c2 = ds_cnt;
    kb_press(8'h41);
    txn(16'hFE00, 16'h0, 0, 1, 0, 0, 0, 8'h00);
    chk("kbsr_full", mdr_out, 16'h8000);
    txn(16'hFE02, 16'h0, 0, 1, 0, 0, 0, 8'h00);
    chk("kbdr", mdr_out, 16'h0041);
    txn(16'hFE00, 16'h0, 0, 1, 0, 0, 0, 8'h00);
    chk("kbsr_empty", mdr_out, 16'h0000);
    txn(16'hFE06, 16'h0042, 1, 1, 0, 0, 0, 8'h00);
    chk("ddr_char", {8'h0, disp_char}, 16'h0042);
    chk("ddr_strobes", 16'(ds_cnt - c2), 16'd1);
    kb_press(8'h10);
    txn(16'hFE02, 16'h0, 0, 1, 0, 0, 1, 8'h20);
    chk("kbdr_old", mdr_out, 16'h0010);
    txn(16'hFE00, 16'h0, 0, 1, 0, 0, 0, 8'h00);
    chk("kbsr_still_full", mdr_out, 16'h8000);
    txn(16'hFE02, 16'h0, 0, 1, 0, 0, 0, 8'h00);
    chk("kbdr_new", mdr_out, 16'h0020);
    chk("mmio_no_req", 16'(req_cyc - c0), 16'd0);
`else
    c0 = req_cyc;
    kb_press(8'h41);
    txn(16'hFE00, 16'h7777, 0, 2, 0, 0, 0, 8'h00);
    chk("fe00_ext_mdr", mdr_out, 16'h7777);
    chk("fe00_ext_req", 16'(req_cyc - c0), 16'd2);
`endif

    c3 = r_cnt;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 2) == 0) ? 16'hFE00 + 16'(2 * $urandom_range(0, 3)) : 16'($urandom);
      if ($urandom_range(0, 4) == 0) kb_press(8'($urandom));
      txn(a, 16'($urandom), 1'($urandom), $urandom_range(1, 4), $urandom_range(0, 3),
          $urandom_range(0, 3) == 0, 0, 8'h00);
    end
    chk("random_r_pulses", 16'(r_cnt - c3), 16'd40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
